btb_bht_sat: RTL
================

Name: btb_bht_sat

Overview:
- Next-generation branch predictor for the 5-stage RV32I core: direct-mapped BTB with per-entry valid bit and N-bit saturating-counter BHT, replacing the 1-bit predictor.
- IF stage: combinational lookup of PC_origin_IF gives predicted target and taken flag.
- EX stage: resolved conditional branches update the table, and the block reports mispredicts.
- Free-running branch/mispredict statistics counters support CPI/accuracy measurement.

Parameters:
- ENTRY_ADDR_LEN, 6: index bits; table depth = 2^ENTRY_ADDR_LEN (legal 2..12).
- CNT_WIDTH, 2: saturating-counter width (legal 1..4); counter MSB = predict taken.
- STAT_WIDTH, 32: width of statistics counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PC_origin_IF  in  32  PC being fetched.
- PC_pred_IF  out  32  predicted target; 0 when PC_pred_en_IF=0.
- PC_pred_en_IF  out  1  predict taken (redirect fetch to PC_pred_IF).
- valid_EX  in  1  EX holds a real (not flushed/bubble) instruction.
- opcode_EX  in  7  opcode of EX instruction; only 7'b1100011 (BRANCH) updates.
- PC_origin_EX  in  32  PC of EX instruction.
- PC_target_EX  in  32  computed branch target.
- br_EX  in  1  branch resolved taken.
- pred_en_EX  in  1  PC_pred_en_IF value pipelined to EX with this instruction.
- pred_target_EX  in  32  PC_pred_IF value pipelined to EX.
- mispred_EX  out  1  combinational: a counted branch was mispredicted.
- br_cnt  out  STAT_WIDTH  branches resolved.
- mispred_cnt  out  STAT_WIDTH  mispredictions.

Behaviour:
- Addressing: index = PC[ENTRY_ADDR_LEN+1:2]; tag = PC[31:ENTRY_ADDR_LEN+2]; PC[1:0] ignored.
- Per-entry state: valid (1b), tag, target (32b), cnt (CNT_WIDTH).
- Lookup (combinational, same cycle as IF):
  - hit = valid[idx] && tag[idx] == tag_IF.
  - PC_pred_en_IF = hit && cnt[idx][MSB].
  - PC_pred_IF = target[idx] when PC_pred_en_IF, else 0.
- upd = valid_EX && opcode_EX == 7'b1100011. All writes happen on the rising edge when upd=1 and rst=0.
- Update when the EX PC hits (valid and tag match):
  - cnt saturating: +1 if br_EX (holds at 2^CNT_WIDTH-1), -1 if !br_EX (holds at 0).
  - target <= PC_target_EX only when br_EX.
- Update when the EX PC misses (allocate/replace):
  - valid <= 1; tag <= tag_EX; target <= PC_target_EX.
  - cnt <= 2^(CNT_WIDTH-1) if br_EX (weakly taken), else 2^(CNT_WIDTH-1)-1 (weakly not-taken).
  - For CNT_WIDTH=1 the two init values are 1 and 0.
- mispred_EX = upd && ((pred_en_EX != br_EX) || (br_EX && pred_en_EX && pred_target_EX != PC_target_EX)); 0 when !upd.
- Statistics:
  - br_cnt += 1 per upd cycle.
  - mispred_cnt += 1 per mispred_EX cycle.
  - Both saturate at all-ones; no wrap.
- Same-cycle IF read and EX write to the same index: IF sees pre-edge contents, no bypass. The write becomes visible the following cycle.
- Non-branch opcodes and valid_EX=0 cycles: no table or statistics change.
- Reset (synchronous, any cycle including mid-stream):
  - Next edge clears all valid, tag, target and cnt to 0, and clears br_cnt and mispred_cnt.
  - An update presented in the reset cycle is discarded.
  - While rst=1: PC_pred_en_IF=0, PC_pred_IF=0, mispred_EX=0.

Test Plan:
- Reset then lookup PC 0x100 -> PC_pred_en_IF=0, PC_pred_IF=0, br_cnt=0, mispred_cnt=0.
- Branch 0x100 taken to 0x80 (pred_en_EX=0) -> mispred_EX=1. Next cycle IF 0x100 -> PC_pred_en_IF=1, PC_pred_IF=0x80, cnt=2, br_cnt=1, mispred_cnt=1.
- Hysteresis, CNT_WIDTH=2:
  - 0x100 resolved taken 3 more times -> cnt saturates at 3.
  - One not-taken -> cnt=2, still predicts taken.
  - Second not-taken -> cnt=1, PC_pred_en_IF=0.
- Aliasing:
  - 0x100 then 0x100+(4<<ENTRY_ADDR_LEN) (=0x200 at default 6) resolved taken to 0x40 -> entry replaced.
  - IF 0x100 -> miss, pred 0.
  - IF 0x200 -> pred 0x40, cnt=2.
- Same-index IF/EX same cycle: IF 0x100 while EX allocates 0x100 -> IF output is old (0); one cycle later prediction is valid.
- Filtering and reset: valid_EX=0 branch or opcode 0110011 -> no change. rst asserted during a branch update -> after edge all predictions 0 and statistics 0. Run 2^STAT_WIDTH+ events (STAT_WIDTH=4) -> counters hold at 15.

Source files
------------

// File: rtl/btb_bht_sat.sv
// Branch predictor: direct-mapped BTB with an N-bit saturating-counter BHT.
// It does a combinational IF lookup, takes updates from resolved EX branches, and keeps saturating statistics.
module btb_bht_sat #(
    parameter int unsigned ENTRY_ADDR_LEN = 6,
    parameter int unsigned CNT_WIDTH      = 2,
    parameter int unsigned STAT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           PC_origin_IF,
    output logic [31:0]           PC_pred_IF,
    output logic                  PC_pred_en_IF,
    input  logic                  valid_EX,
    input  logic [6:0]            opcode_EX,
    input  logic [31:0]           PC_origin_EX,
    input  logic [31:0]           PC_target_EX,
    input  logic                  br_EX,
    input  logic                  pred_en_EX,
    input  logic [31:0]           pred_target_EX,
    output logic                  mispred_EX,
    output logic [STAT_WIDTH-1:0] br_cnt,
    output logic [STAT_WIDTH-1:0] mispred_cnt
);

    localparam int unsigned DEPTH = 1 << ENTRY_ADDR_LEN;
    localparam int unsigned TAG_W = 30 - ENTRY_ADDR_LEN;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_WT  = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WT - CNT_WIDTH'(1);

    logic                  valid_q  [DEPTH];
    logic [TAG_W-1:0]      tag_q    [DEPTH];
    logic [31:0]           target_q [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q    [DEPTH];

    logic [ENTRY_ADDR_LEN-1:0] idx_if, idx_ex;
    logic [TAG_W-1:0]          tag_if, tag_ex;
    logic                      hit_if, hit_ex, upd, mispred;
    logic [CNT_WIDTH-1:0]      cnt_cur, cnt_nxt;
    logic                      unused_pc_lsb;

    assign idx_if = PC_origin_IF[ENTRY_ADDR_LEN+1:2];
    assign tag_if = PC_origin_IF[31:ENTRY_ADDR_LEN+2];
    assign idx_ex = PC_origin_EX[ENTRY_ADDR_LEN+1:2];
    assign tag_ex = PC_origin_EX[31:ENTRY_ADDR_LEN+2];
    assign unused_pc_lsb = ^{PC_origin_IF[1:0], PC_origin_EX[1:0]};

    // IF lookup reads pre-edge contents; there is no bypass from a same-cycle EX write.
    always_comb begin
        hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        PC_pred_en_IF = !rst && hit_if && cnt_q[idx_if][CNT_WIDTH-1];
        PC_pred_IF    = PC_pred_en_IF ? target_q[idx_if] : 32'd0;
    end

    // EX resolution: update qualifier, mispredict detection, next counter value.
    always_comb begin
        upd     = !rst && valid_EX && (opcode_EX == OP_BRANCH);
        hit_ex  = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
        mispred = upd && ((pred_en_EX != br_EX) ||
                          (br_EX && pred_en_EX && (pred_target_EX != PC_target_EX)));
        cnt_cur = cnt_q[idx_ex];
        cnt_nxt = cnt_cur;
        if (br_EX) begin
            if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_WIDTH'(1);
        end else begin
            if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_WIDTH'(1);
        end
    end

    assign mispred_EX = mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd) begin
                if (hit_ex) begin
                    cnt_q[idx_ex] <= cnt_nxt;
                    if (br_EX) target_q[idx_ex] <= PC_target_EX;
                end else begin
                    // Allocate or replace, starting at the weak state in the resolved direction.
                    valid_q[idx_ex]  <= 1'b1;
                    tag_q[idx_ex]    <= tag_ex;
                    target_q[idx_ex] <= PC_target_EX;
                    cnt_q[idx_ex]    <= br_EX ? CNT_WT : CNT_WNT;
                end
                if (br_cnt != '1) br_cnt <= br_cnt + STAT_WIDTH'(1);
            end
            if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + STAT_WIDTH'(1);
        end
    end

endmodule
